// File: rtl/windowed_accumulator_pkg.sv
// Shared types and helpers for the windowed accumulator.
// Holds the controller state encoding and a constant-width helper used to
// size the per-window sample counter.
package acc_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    // Bits needed to index 'value' distinct codes (minimum 1).
    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value - 1;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/windowed_accumulator_if.sv
// Sample-in / result-out handshake bundle for the windowed accumulator.
// slave is the accumulator's view, master is the producer/consumer view.
interface windowed_accumulator_if #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic [ACC_W-1:0]  sum_live;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, sum_live
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, sum_live
    );
endinterface

// File: rtl/windowed_accumulator_adder.sv
// Ripple-carry adder with carry-out, written as explicit XOR/AND/OR
// full-adder cells so every bit's carry path stays visible in timing reports.
module acc_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0]   c;
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W-1:0] t;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign p[i]   = a[i] ^ b[i];
        assign sum[i] = p[i] ^ c[i];
        assign g[i]   = a[i] & b[i];
        assign t[i]   = p[i] & c[i];
        assign c[i+1] = g[i] | t[i];
    end

    assign cout = c[W];
endmodule

// File: rtl/windowed_accumulator.sv
// Windowed accumulator: sums WINDOW unsigned samples and hands each total
// downstream over a valid/ready handshake, with a registered input stage,
// sticky per-window overflow flag and a synchronous clear.
// Optional build macro ACC_SAT_EN: clamp the accumulator at all-ones after a
// carry-out instead of wrapping.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | accepting samples, in_ready high unless clear
// DRAIN | window full, last sample still in the input register
// HOLD  | result presented, outputs frozen until out_ready
module windowed_accumulator
    import acc_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 8,
    parameter int WINDOW = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    windowed_accumulator_if.slave bus
);
    localparam int               CNT_W    = clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW);

    acc_state_t        state;
    acc_state_t        state_nxt;
    logic [DATA_W-1:0] b_reg;
    logic              b_vld;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              ovf_win;
    logic              out_valid;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              in_ready;
    logic              accept;
    logic              accept_last;
    logic              win_done;
    logic [ACC_W-1:0]  add_sum;
    logic              add_cout;
    logic              carry;
    logic [ACC_W-1:0]  acc_next;

    assign in_ready    = (state == RUN) && !clear;
    assign accept      = bus.in_valid && in_ready;
    assign cnt_inc     = cnt + 1'b1;
    assign accept_last = accept && (cnt_inc == CNT_LAST);

    acc_adder #(.W(ACC_W)) u_adder (
        .a    (acc),
        .b    (ACC_W'(b_reg)),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign carry = b_vld && add_cout;

`ifdef ACC_SAT_EN
    // Once a carry has been seen this window the total is pinned at full scale.
    assign acc_next = (ovf_win || carry) ? '1 : add_sum;
`else
    assign acc_next = add_sum;
`endif

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; clear always returns the controller to RUN.
    always_comb begin
        state_nxt = state;
        win_done  = 1'b0;
        unique case (state)
            RUN: begin
                if (accept_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (b_vld) begin
                    win_done  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && bus.out_ready) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (clear) begin
            state_nxt = RUN;
            win_done  = 1'b0;
        end
    end

    // Input register, accumulator, counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_reg     <= '0;
            b_vld     <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf_win   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (clear) begin
            b_vld     <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf_win   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            b_vld <= accept;
            if (accept) begin
                b_reg <= bus.in_data;
                cnt   <= cnt_inc;
            end
            if (win_done) begin
                out_sum   <= acc_next;
                out_ovf   <= ovf_win || carry;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
                ovf_win   <= 1'b0;
            end else begin
                if (b_vld) begin
                    acc     <= acc_next;
                    ovf_win <= ovf_win || carry;
                end
                if (out_valid && bus.out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = out_sum;
    assign bus.out_ovf   = out_ovf;
    assign bus.sum_live  = acc;
endmodule

// File: tb/tb_windowed_accumulator.sv
// Bench for windowed_accumulator: directed scenarios plus a randomized phase,
// with a window-level reference model (sum of accepted samples) checking
// every result and the in_ready behaviour.
module tb_windowed_accumulator;

    localparam int DATA_W = 4;
    localparam int ACC_W  = 8;
    localparam int WINDOW = 4;
    localparam int ACC_W2 = 5;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic clear2;

    always #5 clk = ~clk;

    windowed_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W))  bus ();
    windowed_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W2)) bus2 ();

    windowed_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .WINDOW(WINDOW)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    windowed_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W2), .WINDOW(WINDOW)) u_dut5 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear2),
        .bus   (bus2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: window total from the samples alone.
    function automatic int model_sum(input int q[$], input int accw);
        int total;
        int maxv;
        total = 0;
        foreach (q[i]) total += q[i];
        maxv = (1 << accw) - 1;
`ifdef ACC_SAT_EN
        return (total > maxv) ? maxv : total;
`else
        return total % (1 << accw);
`endif
    endfunction

    function automatic int model_ovf(input int q[$], input int accw);
        int total;
        total = 0;
        foreach (q[i]) total += q[i];
        return (total > (1 << accw) - 1) ? 1 : 0;
    endfunction

    // Scoreboard for the main instance, evaluated mid-cycle on the values
    // that the next rising edge will act on.
    int win_q[$];
    int exp_sum_q[$];
    int exp_ovf_q[$];
    bit blocked = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            win_q.delete();
            exp_sum_q.delete();
            exp_ovf_q.delete();
            blocked = 1'b0;
        end else begin
            chk("in_ready", bus.in_ready, (!blocked && !clear));
            if (bus.out_valid) begin
                chk("spurious_valid", exp_sum_q.size() != 0, 1);
            end
            if (clear) begin
                win_q.delete();
                exp_sum_q.delete();
                exp_ovf_q.delete();
                blocked = 1'b0;
            end else begin
                if (bus.out_valid && bus.out_ready && exp_sum_q.size() > 0) begin
                    chk("out_sum", bus.out_sum, exp_sum_q[0]);
                    chk("out_ovf", bus.out_ovf, exp_ovf_q[0]);
                    void'(exp_sum_q.pop_front());
                    void'(exp_ovf_q.pop_front());
                    blocked = 1'b0;
                end
                if (bus.in_valid && bus.in_ready) begin
                    win_q.push_back(int'(bus.in_data));
                    if (win_q.size() == WINDOW) begin
                        exp_sum_q.push_back(model_sum(win_q, ACC_W));
                        exp_ovf_q.push_back(model_ovf(win_q, ACC_W));
                        win_q.delete();
                        blocked = 1'b1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        chk(tag, bus.out_valid, 1);
    endtask

    task automatic send4(input int a, input int b, input int c, input int d);
        int s[4];
        s = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'(s[i]);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int live_exp[4];
        int s2[4];
        int q4[$];
        int nres;
        int n;

        rst           = 1'b1;
        clear         = 1'b0;
        clear2        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.in_data  = '0;
        bus2.out_ready = 1'b0;

        // T1 reset
        step();
        step();
        rst = 1'b0;
        chk("t1_out_valid", bus.out_valid, 0);
        chk("t1_sum_live", bus.sum_live, 0);
        chk("t1_out_ovf", bus.out_ovf, 0);
        chk("t1_out_sum", bus.out_sum, 0);
        chk("t1_in_ready", bus.in_ready, 1);

        // T2 stream 3,5,7,1 with sum_live trace
        bus.out_ready = 1'b1;
        s2 = '{3, 5, 7, 1};
        live_exp = '{0, 3, 8, 15};
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'(s2[i]);
            step();
            chk("t2_sum_live", bus.sum_live, live_exp[i]);
        end
        bus.in_valid = 1'b0;
        step();
        chk("t2_out_valid", bus.out_valid, 1);
        chk("t2_out_sum", bus.out_sum, 16);
        chk("t2_out_ovf", bus.out_ovf, 0);
        chk("t2_sum_live_zero", bus.sum_live, 0);
        chk("t2_in_ready_hold", bus.in_ready, 0);
        step();
        chk("t2_valid_pulse", bus.out_valid, 0);
        chk("t2_in_ready_back", bus.in_ready, 1);

        // Throughput: continuous input, one result every WINDOW+2 cycles
        nres = 0;
        for (int i = 0; i < 4 * (WINDOW + 2); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'($urandom_range(0, 15));
            step();
            if (bus.out_valid) nres++;
        end
        bus.in_valid = 1'b0;
        chk("throughput", nres, 4);
        step();

        // T3 backpressure
        bus.out_ready = 1'b0;
        send4(3, 5, 7, 1);
        wait_valid("t3_valid");
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'(9);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_sum", bus.out_sum, 16);
            chk("t3_hold_valid", bus.out_valid, 1);
            chk("t3_hold_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("t3_release_valid", bus.out_valid, 0);
        chk("t3_release_ready", bus.in_ready, 1);

        // T4 overflow on the narrow instance
        q4 = '{15, 15, 15, 15};
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_data  = DATA_W'(q4[i]);
            step();
        end
        bus2.in_valid = 1'b0;
        n = 0;
        while (!bus2.out_valid && n < 20) begin
            step();
            n++;
        end
        chk("t4_valid", bus2.out_valid, 1);
        chk("t4_out_sum", bus2.out_sum, model_sum(q4, ACC_W2));
        chk("t4_out_ovf", bus2.out_ovf, 1);
        step();

        // T5 clear mid-window (a sample offered during clear must be ignored)
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'(9);
        step();
        step();
        bus.in_data = DATA_W'(7);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t5_live_cleared", bus.sum_live, 0);
        send4(1, 2, 3, 4);
        wait_valid("t5_valid");
        chk("t5_out_sum", bus.out_sum, 10);
        chk("t5_out_ovf", bus.out_ovf, 0);
        step();

        // T6 reset while holding a result
        bus.out_ready = 1'b0;
        send4(2, 2, 2, 2);
        wait_valid("t6_valid");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_out_valid", bus.out_valid, 0);
        chk("t6_in_ready", bus.in_ready, 1);
        chk("t6_sum_live", bus.sum_live, 0);
        chk("t6_out_sum", bus.out_sum, 0);
        bus.out_ready = 1'b1;
        send4(1, 1, 1, 1);
        wait_valid("t6_valid2");
        chk("t6_out_sum2", bus.out_sum, 4);
        step();

        // Randomized traffic with occasional clears
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = DATA_W'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            clear         = ($urandom_range(0, 39) == 0);
            step();
        end
        bus.in_valid  = 1'b0;
        clear         = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
